// File: rtl/bist_pkg.sv
// ============================================================================
// Module   : bist_pkg
// Purpose  : Shared types and widths for the full-adder BIST controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bist_pkg;

  localparam int SIG_W  = 4;  // MISR signature width
  localparam int RESP_W = 2;  // CUT response {Cout,Sum}

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bist_pattern_counter.sv
// ============================================================================
// Module   : bist_pattern_counter
// Purpose  : Counts RUN cycles; flags the final pattern of the sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bist_pattern_counter #(
  parameter int PATTERN_COUNT = 8,
  parameter int CNT_W         = $clog2(PATTERN_COUNT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(PATTERN_COUNT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt  = r_cnt;
  assign last = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/bist_controller.sv
// ============================================================================
// Module   : bist_controller
// Purpose  : Sequences TPG -> CUT -> MISR BIST and grades the final signature.
//            Optional macro BIST_SIG_READBACK_EN adds the sig_captured output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bist_controller
  import bist_pkg::*;
#(
  parameter int               PATTERN_COUNT = 8,
  parameter logic [SIG_W-1:0] GOLDEN_SIG    = 4'b0000,
  parameter int               CNT_W         = $clog2(PATTERN_COUNT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] misr_sig,
  output logic             test_mode,
  output logic             tpg_seed,
  output logic             tpg_en,
  output logic             ora_clr,
  output logic             ora_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
`ifdef BIST_SIG_READBACK_EN
  output logic             fail,
  output logic [SIG_W-1:0] sig_captured
`else
  output logic             fail
`endif
);

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] w_cnt;
  logic             w_last;
  logic             w_runExit;
  logic             w_match;
  logic             w_active;
  logic             w_grade;
  logic             r_pass;
  logic             r_fail;

  bist_pattern_counter #(
    .PATTERN_COUNT(PATTERN_COUNT),
    .CNT_W        (CNT_W)
  ) u_patternCounter (
    .clock(clock),
    .reset(reset),
    .clr  (r_state == INIT),
    .en   (r_state == RUN),
    .cnt  (w_cnt),
    .last (w_last)
  );

  // The overrun term only matters if the counter is ever upset past the end.
  assign w_runExit = w_last || (w_cnt >= CNT_W'(PATTERN_COUNT));
  assign w_match   = (misr_sig == GOLDEN_SIG);
  assign w_active  = (r_state == INIT) || (r_state == RUN) || (r_state == CHECK);
  assign w_grade   = (r_state == CHECK) && (w_nextState == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = INIT;
      INIT:    w_nextState = RUN;
      RUN:     if (w_runExit) w_nextState = CHECK;
      CHECK:   w_nextState = DONE;
      DONE:    if (!start) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
    if (w_active && abort) begin
      w_nextState = IDLE;
    end
  end

  always_comb begin
    test_mode = 1'b0;
    tpg_seed  = 1'b0;
    tpg_en    = 1'b0;
    ora_clr   = 1'b0;
    ora_en    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      INIT: begin
        test_mode = 1'b1;
        tpg_seed  = 1'b1;
        ora_clr   = 1'b1;
        busy      = 1'b1;
      end
      RUN: begin
        test_mode = 1'b1;
        tpg_en    = 1'b1;
        ora_en    = 1'b1;
        busy      = 1'b1;
      end
      CHECK: begin
        test_mode = 1'b1;
        busy      = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Results live only in DONE; any other destination clears them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pass <= 1'b0;
      r_fail <= 1'b0;
    end else if (w_grade) begin
      r_pass <= w_match;
      r_fail <= ~w_match;
    end else if (w_nextState != DONE) begin
      r_pass <= 1'b0;
      r_fail <= 1'b0;
    end
  end

  assign pass = r_pass;
  assign fail = r_fail;

`ifdef BIST_SIG_READBACK_EN
  logic [SIG_W-1:0] r_sigCaptured;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sigCaptured <= '0;
    end else if (r_state == INIT) begin
      r_sigCaptured <= '0;
    end else if (w_grade) begin
      r_sigCaptured <= misr_sig;
    end
  end

  assign sig_captured = r_sigCaptured;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bist_controller.sv
// ============================================================================
// Module   : tb_bist_controller
// Purpose  : Self-checking bench; phase-index model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bist_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] startV;
  logic [1:0] abortV;
  logic [3:0] sigV [2];
  logic [1:0] tmV, seedV, tenV, clrV, oenV, busyV, doneV, passV, failV;
`ifdef BIST_SIG_READBACK_EN
  logic [3:0] capV [2];
`endif

  int nChecks = 0;
  int nFail   = 0;
  bit running = 1'b0;

  always #5 clock = ~clock;

  bist_controller #(.PATTERN_COUNT(8), .GOLDEN_SIG(4'b1010)) dut8 (
    .clock(clock), .reset(reset), .start(startV[0]), .abort(abortV[0]),
    .misr_sig(sigV[0]), .test_mode(tmV[0]), .tpg_seed(seedV[0]),
    .tpg_en(tenV[0]), .ora_clr(clrV[0]), .ora_en(oenV[0]), .busy(busyV[0]),
    .done(doneV[0]), .pass(passV[0]),
`ifdef BIST_SIG_READBACK_EN
    .fail(failV[0]), .sig_captured(capV[0])
`else
    .fail(failV[0])
`endif
  );

  bist_controller #(.PATTERN_COUNT(1), .GOLDEN_SIG(4'b0011)) dut1 (
    .clock(clock), .reset(reset), .start(startV[1]), .abort(abortV[1]),
    .misr_sig(sigV[1]), .test_mode(tmV[1]), .tpg_seed(seedV[1]),
    .tpg_en(tenV[1]), .ora_clr(clrV[1]), .ora_en(oenV[1]), .busy(busyV[1]),
    .done(doneV[1]), .pass(passV[1]),
`ifdef BIST_SIG_READBACK_EN
    .fail(failV[1]), .sig_captured(capV[1])
`else
    .fail(failV[1])
`endif
  );

  function automatic int pcOf(input int i);
    return (i == 0) ? 8 : 1;
  endfunction

  function automatic logic [3:0] goldOf(input int i);
    return (i == 0) ? 4'b1010 : 4'b0011;
  endfunction

  // Model: ph counts cycles since start was accepted.
  // 0 idle, 1 init, 2..PC+1 run, PC+2 check, PC+3 done.
  int         ph    [2];
  logic       mPass [2];
  logic       mFail [2];
  logic [3:0] mSig  [2];

  always @(posedge clock or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        ph[i] <= 0; mPass[i] <= 1'b0; mFail[i] <= 1'b0; mSig[i] <= 4'h0;
      end else if (ph[i] == 0) begin
        if (startV[i]) ph[i] <= 1;
      end else if (ph[i] == pcOf(i) + 3) begin
        if (!startV[i]) begin
          ph[i] <= 0; mPass[i] <= 1'b0; mFail[i] <= 1'b0;
        end
      end else if (abortV[i]) begin
        ph[i] <= 0; mPass[i] <= 1'b0; mFail[i] <= 1'b0;
      end else if (ph[i] == pcOf(i) + 2) begin
        ph[i]    <= ph[i] + 1;
        mPass[i] <= (sigV[i] == goldOf(i));
        mFail[i] <= (sigV[i] != goldOf(i));
        mSig[i]  <= sigV[i];
      end else begin
        if (ph[i] == 1) mSig[i] <= 4'h0;
        ph[i] <= ph[i] + 1;
      end
    end
  end

  function automatic logic [8:0] actOut(input int i);
    return {tmV[i], seedV[i], tenV[i], clrV[i], oenV[i], busyV[i], doneV[i], passV[i], failV[i]};
  endfunction

  function automatic logic [8:0] expOut(input int i);
    int p  = ph[i];
    int pc = pcOf(i);
    logic act = (p >= 1) && (p <= pc + 2);
    logic run = (p >= 2) && (p <= pc + 1);
    return {act, p == 1, run, p == 1, run, act, p == pc + 3, mPass[i], mFail[i]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (running && !reset) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("outputs[dut%0d] {tm,seed,ten,clr,oen,busy,done,pass,fail}", i),
              32'(actOut(i)), 32'(expOut(i)));
`ifdef BIST_SIG_READBACK_EN
        check($sformatf("sig_captured[dut%0d]", i), 32'(capV[i]), 32'(mSig[i]));
`endif
      end
    end
  end

  // Drives one test from the current negedge; returns observed activity.
  task automatic runTest(input int i, input bit hold, input int pulseK,
                         output int enCnt, output int seedCnt, output logic doneBefore);
    int pc = pcOf(i);
    enCnt = 0; seedCnt = 0; doneBefore = 1'b0;
    startV[i] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    if (!hold) startV[i] = 1'b0;
    enCnt += int'(tenV[i] & oenV[i]);
    seedCnt += int'(seedV[i] & clrV[i]);
    for (int k = 1; k <= pc + 2; k++) begin
      @(negedge clock);
      if (k == pulseK) startV[i] = 1'b1;
      else if (k == pulseK + 1) startV[i] = 1'b0;
      enCnt += int'(tenV[i] & oenV[i]);
      seedCnt += int'(seedV[i] & clrV[i]);
      if (k == pc + 1) doneBefore = doneV[i];
    end
  endtask

  int   enCnt, seedCnt;
  logic doneBefore;
  bit   sawDone;

  initial begin
    reset = 1'b1; startV = 2'b00; abortV = 2'b00;
    sigV[0] = 4'b1010; sigV[1] = 4'b0011;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post-reset outputs dut8", 32'(actOut(0)), 32'h0);
    check("post-reset outputs dut1", 32'(actOut(1)), 32'h0);
    running = 1'b1;

    // Mid-test asynchronous reset
    startV[0] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    startV[0] = 1'b0;
    repeat (2) @(negedge clock);
    check("busy before mid-test reset", 32'(busyV[0]), 32'h1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1 check("async reset clears outputs", 32'(actOut(0)), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("idle after reset release", 32'(actOut(0)), 32'h0);

    // Passing run
    runTest(0, 1'b0, -1, enCnt, seedCnt, doneBefore);
    check("tpg_en/ora_en cycles", 32'(enCnt), 32'd8);
    check("seed/clr cycles", 32'(seedCnt), 32'd1);
    check("done low after E0+9", 32'(doneBefore), 32'h0);
    check("pass run {done,pass,fail}", 32'({doneV[0], passV[0], failV[0]}), 32'b110);

    // Failing run
    @(negedge clock);
    sigV[0] = 4'b0101;
    @(negedge clock);
    runTest(0, 1'b0, -1, enCnt, seedCnt, doneBefore);
    check("fail run {done,pass,fail}", 32'({doneV[0], passV[0], failV[0]}), 32'b101);
`ifdef BIST_SIG_READBACK_EN
    check("sig_captured on fail", 32'(capV[0]), 32'h5);
`endif
    sigV[0] = 4'b1010;
    repeat (2) @(negedge clock);

    // Abort on the 4th RUN cycle
    startV[0] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    startV[0] = 1'b0;
    repeat (4) @(negedge clock);
    check("4th RUN cycle active", 32'(tenV[0]), 32'h1);
    abortV[0] = 1'b1;
    @(negedge clock);
    abortV[0] = 1'b0;
    check("abort -> idle outputs", 32'(actOut(0)), 32'h0);
    sawDone = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (doneV[0]) sawDone = 1'b1;
    end
    check("no DONE after abort", 32'(sawDone), 32'h0);

    // Start held high through DONE
    runTest(0, 1'b1, -1, enCnt, seedCnt, doneBefore);
    check("held run {done,pass,fail}", 32'({doneV[0], passV[0], failV[0]}), 32'b110);
    repeat (4) @(negedge clock);
    check("DONE held with start high", 32'({doneV[0], passV[0], failV[0]}), 32'b110);
    startV[0] = 1'b0;
    @(negedge clock);
    check("drop start -> idle", 32'(actOut(0)), 32'h0);
    runTest(0, 1'b0, -1, enCnt, seedCnt, doneBefore);
    check("rerun tpg_en cycles", 32'(enCnt), 32'd8);
    check("rerun {done,pass,fail}", 32'({doneV[0], passV[0], failV[0]}), 32'b110);

    // PATTERN_COUNT=1 with start pulsed during RUN
    runTest(1, 1'b0, 1, enCnt, seedCnt, doneBefore);
    check("pc1 tpg_en cycles", 32'(enCnt), 32'd1);
    check("pc1 done low after E0+2", 32'(doneBefore), 32'h0);
    check("pc1 {done,pass,fail}", 32'({doneV[1], passV[1], failV[1]}), 32'b110);
    @(negedge clock);
    check("pc1 back to idle", 32'(actOut(1)), 32'h0);
    repeat (3) @(negedge clock);

    running = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

`default_nettype wire
